// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface if_fetch_unit_if #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned INSTR_WIDTH = 32
);
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_ack;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over imem req/ack, prefetch FIFO, stall and redirect.
// Define FETCH_PERF_CNT_EN to add the perf_bubble_cnt output (saturating IF bubble counter).
module if_fetch_unit #(
  parameter int unsigned         PC_WIDTH    = 32,
  parameter int unsigned         INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = {PC_WIDTH{1'b0}},
  parameter int unsigned         FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  if_fetch_unit_if.master        imem,
  input  logic                   ID_STALL,
  input  logic                   redirect_en,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic [INSTR_WIDTH-1:0] IF_INSTRUCTION,
  output logic [PC_WIDTH-1:0]    IF_PC,
  output logic                   IF_VALID
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            perf_bubble_cnt
`endif
);

  localparam int unsigned         PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned         CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0]    PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]    PTR_ONE  = PTR_W'(1'b1);
  localparam logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(3'd4);
  localparam logic [PC_WIDTH-1:0] PC_ALIGN = ~PC_WIDTH'(2'b11);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic [PC_WIDTH-1:0]    pc_r;
  logic [PC_WIDTH-1:0]    drain_addr_r;
  logic [PC_WIDTH-1:0]    fifo_pc_r    [FIFO_DEPTH];
  logic [INSTR_WIDTH-1:0] fifo_instr_r [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [CNT_W-1:0]       count_r;
  logic [CNT_W-1:0]       count_after_s;
  logic                   ack_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   if_valid_s;
  logic                   imem_req_s;
  logic [PC_WIDTH-1:0]    imem_addr_s;
  logic [PC_WIDTH-1:0]    redirect_target_s;

  // FIFO push/pop qualification; redirect overrides both
  always_comb begin
    ack_s             = imem.imem_ack;
    redirect_target_s = redirect_pc & PC_ALIGN;
    if_valid_s        = (count_r != CNT_ZERO) && !redirect_en;
    pop_s             = if_valid_s && !ID_STALL;
    push_s            = (state_r == ST_FETCH) && ack_s && !redirect_en;
    count_after_s     = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        state_next_s = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect_en) begin
          state_next_s = ack_s ? ST_FETCH : ST_DRAIN;
        end else if (ack_s && (count_after_s == CNT_FULL)) begin
          state_next_s = ST_HOLD;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (redirect_en || (count_after_s != CNT_FULL)) begin
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        if (ack_s) begin
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs and IF/ID presentation (bubble reads as all-zero)
  always_comb begin
    imem_req_s  = 1'b0;
    imem_addr_s = pc_r;
    case (state_r)
      ST_FETCH: begin
        imem_req_s  = 1'b1;
        imem_addr_s = pc_r;
      end
      ST_DRAIN: begin
        imem_req_s  = 1'b1;
        imem_addr_s = drain_addr_r;
      end
      default: begin
        imem_req_s  = 1'b0;
        imem_addr_s = pc_r;
      end
    endcase
    if (if_valid_s) begin
      IF_VALID       = 1'b1;
      IF_INSTRUCTION = fifo_instr_r[rd_ptr_r];
      IF_PC          = fifo_pc_r[rd_ptr_r];
    end else begin
      IF_VALID       = 1'b0;
      IF_INSTRUCTION = {INSTR_WIDTH{1'b0}};
      IF_PC          = {PC_WIDTH{1'b0}};
    end
  end

  assign imem.imem_req  = imem_req_s;
  assign imem.imem_addr = imem_addr_s;

  // PC, drain address and FIFO bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r         <= RESET_PC;
      drain_addr_r <= RESET_PC;
      wr_ptr_r     <= PTR_ZERO;
      rd_ptr_r     <= PTR_ZERO;
      count_r      <= CNT_ZERO;
    end else if (redirect_en) begin
      pc_r     <= redirect_target_s;
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      // The unacked request keeps its original address on the bus until it drains
      if ((state_r == ST_FETCH) && !ack_s) begin
        drain_addr_r <= pc_r;
      end else begin
        drain_addr_r <= drain_addr_r;
      end
    end else begin
      if (push_s) begin
        pc_r     <= pc_r + PC_STEP;
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        pc_r     <= pc_r;
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_after_s;
    end
  end

  // FIFO storage; entries are only observed while count_r is non-zero
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_pc_r[wr_ptr_r]    <= pc_r;
      fifo_instr_r[wr_ptr_r] <= imem.imem_rdata;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_cnt_r;

  // Saturating count of bubble cycles once fetching has started
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt_r <= 32'd0;
    end else if ((state_r != ST_IDLE) && !if_valid_s && (perf_cnt_r != 32'hFFFF_FFFF)) begin
      perf_cnt_r <= perf_cnt_r + 32'd1;
    end else begin
      perf_cnt_r <= perf_cnt_r;
    end
  end

  assign perf_bubble_cnt = perf_cnt_r;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: transaction-level scoreboard model plus hand-computed checkpoints.
module tb_if_fetch_unit;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RST_PC   = 32'h0000_0100;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        ID_STALL;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] IF_INSTRUCTION;
  logic [31:0] IF_PC;
  logic        IF_VALID;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_bubble_cnt;
`endif

  if_fetch_unit_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) imem_bus ();

  if_fetch_unit #(
    .PC_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (imem_bus),
    .ID_STALL       (ID_STALL),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .IF_INSTRUCTION (IF_INSTRUCTION),
    .IF_PC          (IF_PC),
    .IF_VALID       (IF_VALID)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;
  int ack_delay = 0;
  int mem_cnt   = 0;

  // scoreboard model state
  ent_t        exp_q[$];
  logic [31:0] next_addr;
  logic [31:0] req_addr_m;
  logic        req_active;
  logic        stale;
  logic        exp_valid;
  logic        exp_req;
  int          cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // imem responder: acks after ack_delay waiting cycles, decided mid-cycle
  initial begin
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n || !imem_bus.imem_req) begin
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        mem_cnt = 0;
      end else if (mem_cnt >= ack_delay) begin
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);
        mem_cnt = 0;
      end else begin
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        mem_cnt++;
      end
    end
  end

  // compare process: every cycle against the scoreboard model
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      check("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
      check("rst_addr", imem_bus.imem_addr, RST_PC);
      check("rst_valid", {31'd0, IF_VALID}, 32'd0);
      check("rst_instr", IF_INSTRUCTION, 32'd0);
      check("rst_pc", IF_PC, 32'd0);
      exp_q.delete();
      next_addr  = RST_PC;
      req_addr_m = RST_PC;
      req_active = 1'b0;
      stale      = 1'b0;
      cyc        = 0;
    end else begin
      exp_valid = (exp_q.size() != 0) && !redirect_en;
      if (cyc == 0)        exp_req = 1'b0;
      else if (req_active) exp_req = 1'b1;
      else                 exp_req = (exp_q.size() < DEPTH);
      check("if_valid", {31'd0, IF_VALID}, {31'd0, exp_valid});
      if (exp_valid) begin
        check("if_pc", IF_PC, exp_q[0].pc);
        check("if_instr", IF_INSTRUCTION, exp_q[0].instr);
      end else begin
        check("bubble_pc", IF_PC, 32'd0);
        check("bubble_instr", IF_INSTRUCTION, 32'd0);
      end
      check("imem_req", {31'd0, imem_bus.imem_req}, {31'd0, exp_req});
      if (exp_req) begin
        if (!req_active) req_addr_m = next_addr;
        check("imem_addr", imem_bus.imem_addr, req_addr_m);
      end
      if (redirect_en) begin
        exp_q.delete();
        next_addr  = redirect_pc & 32'hFFFF_FFFC;
        stale      = exp_req && !imem_bus.imem_ack;
        req_active = exp_req && !imem_bus.imem_ack;
      end else begin
        if (exp_valid && !ID_STALL) void'(exp_q.pop_front());
        if (exp_req && imem_bus.imem_ack) begin
          if (!stale) begin
            exp_q.push_back({req_addr_m, mem_word(req_addr_m)});
            next_addr = req_addr_m + 32'd4;
          end
          stale      = 1'b0;
          req_active = 1'b0;
        end else begin
          req_active = exp_req;
        end
      end
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    int bubbles;
    rst_n = 1'b0; ID_STALL = 1'b0; redirect_en = 1'b0; redirect_pc = 32'd0; ack_delay = 0;
    repeat (3) @(negedge clk);

    // 1: startup and one instruction per cycle
    rst_n = 1'b1;
    #3 check("t1_idle_req", {31'd0, imem_bus.imem_req}, 32'd0);
    @(negedge clk); #3;
    check("t1_first_req", {31'd0, imem_bus.imem_req}, 32'd1);
    check("t1_first_addr", imem_bus.imem_addr, 32'h100);
    check("t1_no_valid_yet", {31'd0, IF_VALID}, 32'd0);
    @(negedge clk); #3;
    check("t1_pc0", IF_PC, 32'h100);
    check("t1_instr0", IF_INSTRUCTION, 32'h5A5A_0100);
    @(negedge clk); #3 check("t1_pc1", IF_PC, 32'h104);
    @(negedge clk); #3 check("t1_pc2", IF_PC, 32'h108);
    repeat (4) @(negedge clk);

    // 3: stall five cycles, FIFO fills, request stops, outputs hold
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ID_STALL = 1'b1;
      #3;
      check("t3_hold_pc", IF_PC, 32'h11C);
      if (i > 0) check("t3_hold_req", {31'd0, imem_bus.imem_req}, 32'd0);
    end
    @(negedge clk);
    ID_STALL = 1'b0;
    #3 check("t3_release_pc", IF_PC, 32'h11C);
    @(negedge clk); #3;
    check("t3_next_pc", IF_PC, 32'h120);
    check("t3_next_addr", imem_bus.imem_addr, 32'h124);
    repeat (3) @(negedge clk);

    // 2: slow memory, bubbles between instructions
    ack_delay = 3;
    bubbles = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk); #3;
      if (!IF_VALID) bubbles++;
    end
    check("t2_bubbles", {31'd0, bubbles >= 12}, 32'd1);

    // 4: redirect to 0x2003 with a request outstanding
    ack_delay = 2;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (imem_bus.imem_req && mem_cnt == 1) found = 1;
    end
    check("t4_found_outstanding", found, 1);
    redirect_en = 1'b1; redirect_pc = 32'h2003;
    #3 check("t4_redir_valid", {31'd0, IF_VALID}, 32'd0);
    @(negedge clk);
    redirect_en = 1'b0;
    #3;
    check("t4_drain_req", {31'd0, imem_bus.imem_req}, 32'd1);
    check("t4_drain_valid", {31'd0, IF_VALID}, 32'd0);
    @(negedge clk); #3;
    check("t4_new_addr", imem_bus.imem_addr, 32'h2000);
    repeat (3) @(negedge clk);
    ack_delay = 3;
    #3;
    check("t4_first_valid", {31'd0, IF_VALID}, 32'd1);
    check("t4_first_pc", IF_PC, 32'h2000);
    check("t4_first_instr", IF_INSTRUCTION, 32'h5A5A_2000);

    // redirect again while already draining: only the last target counts
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (imem_bus.imem_req && mem_cnt == 0) found = 1;
    end
    check("t4b_found", found, 1);
    redirect_en = 1'b1; redirect_pc = 32'h4000;
    @(negedge clk);
    redirect_pc = 32'h5000;
    @(negedge clk);
    redirect_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ack_delay = 0;
    #3;
    check("t4b_addr", imem_bus.imem_addr, 32'h5000);
    @(negedge clk); #3;
    check("t4b_pc", IF_PC, 32'h5000);
    repeat (3) @(negedge clk);

    // 5: redirect in the same cycle as an ack with FIFO non-empty
    @(negedge clk);
    redirect_en = 1'b1; redirect_pc = 32'h3000;
    #3 check("t5_redir_valid", {31'd0, IF_VALID}, 32'd0);
    @(negedge clk);
    redirect_en = 1'b0;
    #3;
    check("t5_after_valid", {31'd0, IF_VALID}, 32'd0);
    check("t5_after_pc", IF_PC, 32'd0);
    check("t5_after_addr", imem_bus.imem_addr, 32'h3000);
    @(negedge clk); #3 check("t5_pc", IF_PC, 32'h3000);

    // 6: PC wrap, then reset in the middle of a request
    @(negedge clk);
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_en = 1'b0;
    @(negedge clk); #3 check("t6_pc_top", IF_PC, 32'hFFFF_FFFC);
    @(negedge clk); #3;
    check("t6_wrap_valid", {31'd0, IF_VALID}, 32'd1);
    check("t6_wrap_pc", IF_PC, 32'h0);
    check("t6_wrap_instr", IF_INSTRUCTION, 32'h5A5A_0000);
    ack_delay = 3;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk); #3;
      if (imem_bus.imem_req && !imem_bus.imem_ack) found = 1;
    end
    check("t6_found_outstanding", found, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
    check("t6_rst_addr", imem_bus.imem_addr, 32'h100);
    check("t6_rst_valid", {31'd0, IF_VALID}, 32'd0);
    check("t6_rst_pc", IF_PC, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 0;
    @(negedge clk);
    @(negedge clk); #3;
    check("t6_restart_pc", IF_PC, 32'h100);
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
